// File: rtl/studio2_pkg.sv
// Shared types for the Studio II keypad: scancode tables, key index, hold FSM state.
package studio2_pkg;

  typedef logic [3:0] key_idx_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_HELD,
    HS_PEND_REL
  } hold_state_t;

  typedef struct packed {
    logic     hit;
    key_idx_t idx;
  } key_hit_t;

  localparam int unsigned NUM_KEYS = 10;

  localparam logic [7:0] SC_A [NUM_KEYS] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };

  localparam logic [7:0] SC_B [NUM_KEYS] = '{
    8'h4D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44
  };

  function automatic key_hit_t key_lookup(input logic [7:0] code, input logic player_b);
    key_hit_t r;
    r = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if ((player_b ? SC_B[i] : SC_A[i]) == code) begin
        r.hit = 1'b1;
        r.idx = key_idx_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/studio2_key_hold.sv
// One key's minimum-hold stretcher: a release is deferred until HOLD_TICKS ticks
// have elapsed since the most recent press.
module studio2_key_hold
  import studio2_pkg::*;
#(
  parameter logic [3:0] HOLD_TICKS = 4'd10
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic tick,
  input  logic press,
  input  logic rel,
  output logic held
);

  hold_state_t state;
  logic [3:0]  cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= HS_IDLE;
      cnt   <= '0;
      held  <= 1'b0;
    end else if (press) begin
      state <= HS_HELD;
      cnt   <= HOLD_TICKS;
      held  <= 1'b1;
    end else begin
      if (tick && cnt != '0) cnt <= cnt - 4'd1;
      case (state)
        HS_HELD: begin
          if (rel) begin
            state <= (cnt == '0) ? HS_IDLE : HS_PEND_REL;
            held  <= (cnt != '0);
          end
        end
        HS_PEND_REL: begin
          if (cnt == '0) begin
            state <= HS_IDLE;
            held  <= 1'b0;
          end
        end
        HS_IDLE: held <= 1'b0;
        default: begin
          state <= HS_IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/studio2_keypad.sv
// Studio II two-player keypad from PS/2 events, with CPU-selected EF3/EF4 readback.
// Define STUDIO2_KEYPAD_STRETCH_EN to enable minimum-hold stretching of key releases.
module studio2_keypad
  import studio2_pkg::*;
#(
  parameter int unsigned PRESCALE   = 1760,
  parameter logic [3:0]  HOLD_TICKS = 4'd10
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [2:0]  io_n,
  input  logic        io_out,
  input  logic [7:0]  cpu_dout,
  output logic        ef3,
  output logic        ef4,
  output key_idx_t    key_latch,
  output logic [9:0]  keys_a,
  output logic [9:0]  keys_b
);

  logic       armed;
  logic       strobe_prev;
  logic       key_evt;
  key_hit_t   hit_a, hit_b;
  logic [9:0] press_a, rel_a, press_b, rel_b;
  logic       unused_dout;

  assign unused_dout = ^cpu_dout[7:4];

  // armed stays low for the first edge after reset so the strobe is resampled, not treated as an event
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      armed       <= 1'b0;
      strobe_prev <= 1'b0;
    end else begin
      armed       <= 1'b1;
      strobe_prev <= ps2_key[10];
    end
  end

  assign key_evt = armed && (ps2_key[10] != strobe_prev) && !ps2_key[8];

  always_comb begin
    hit_a   = key_lookup(ps2_key[7:0], 1'b0);
    hit_b   = key_lookup(ps2_key[7:0], 1'b1);
    press_a = '0;
    rel_a   = '0;
    press_b = '0;
    rel_b   = '0;
    if (key_evt && hit_a.hit) begin
      if (ps2_key[9]) press_a[hit_a.idx] = 1'b1;
      else            rel_a[hit_a.idx]   = 1'b1;
    end
    if (key_evt && hit_b.hit) begin
      if (ps2_key[9]) press_b[hit_b.idx] = 1'b1;
      else            rel_b[hit_b.idx]   = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      key_latch <= '0;
    end else if (io_out && io_n == 3'd2) begin
      key_latch <= cpu_dout[3:0];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ef3 <= 1'b0;
      ef4 <= 1'b0;
    end else if (key_latch <= 4'd9) begin
      ef3 <= keys_a[key_latch];
      ef4 <= keys_b[key_latch];
    end else begin
      ef3 <= 1'b0;
      ef4 <= 1'b0;
    end
  end

`ifdef STUDIO2_KEYPAD_STRETCH_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)  pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  for (genvar i = 0; i < 10; i++) begin : g_hold
    studio2_key_hold #(.HOLD_TICKS(HOLD_TICKS)) u_hold_a (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .tick    (tick),
      .press   (press_a[i]),
      .rel     (rel_a[i]),
      .held    (keys_a[i])
    );
    studio2_key_hold #(.HOLD_TICKS(HOLD_TICKS)) u_hold_b (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .tick    (tick),
      .press   (press_b[i]),
      .rel     (rel_b[i]),
      .held    (keys_b[i])
    );
  end
`else
  localparam int unsigned unused_cfg = PRESCALE + 32'(HOLD_TICKS);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      keys_a <= '0;
      keys_b <= '0;
    end else begin
      keys_a <= (keys_a & ~rel_a) | press_a;
      keys_b <= (keys_b & ~rel_b) | press_b;
    end
  end
`endif

endmodule

// File: tb/tb_studio2_keypad.sv
// Directed self-checking bench for studio2_keypad; stretch checks build with STUDIO2_KEYPAD_STRETCH_EN.
module tb_studio2_keypad;

  localparam int unsigned TB_PRESCALE = 4;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic [10:0] ps2_key  = '0;
  logic [2:0]  io_n     = '0;
  logic        io_out   = 1'b0;
  logic [7:0]  cpu_dout = '0;
  logic        ef3, ef4;
  logic [3:0]  key_latch;
  logic [9:0]  keys_a, keys_b;

  int unsigned n_tests  = 0;
  int unsigned n_failed = 0;
  logic        strobe   = 1'b0;

  studio2_keypad #(.PRESCALE(TB_PRESCALE), .HOLD_TICKS(4'd3)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .io_n      (io_n),
    .io_out    (io_out),
    .cpu_dout  (cpu_dout),
    .ef3       (ef3),
    .ef4       (ef4),
    .key_latch (key_latch),
    .keys_a    (keys_a),
    .keys_b    (keys_b)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
    strobe  = ~strobe;
    ps2_key = {strobe, pressed, ext, code};
    step();
  endtask

  task automatic out2(input logic [7:0] v);
    io_out   = 1'b1;
    io_n     = 3'd2;
    cpu_dout = v;
    step();
    io_out   = 1'b0;
    io_n     = 3'd0;
  endtask

`ifdef STUDIO2_KEYPAD_STRETCH_EN
  int unsigned edges = 0;
  int unsigned ticks = 0;
  int unsigned t0;

  // Reference prescaler: a tick fires on every TB_PRESCALE-th edge since reset
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      edges <= 0;
      ticks <= 0;
    end else begin
      edges <= edges + 1;
      if (edges % TB_PRESCALE == TB_PRESCALE - 1) ticks <= ticks + 1;
    end
  end

  task automatic wait_ticks(input string tag, input int unsigned start, input int unsigned n);
    int unsigned guard = 0;
    while (ticks - start < n && guard < 40) begin
      check({tag, " held"}, 16'(keys_a[2]), 16'd1);
      step();
      guard++;
    end
    check({tag, " ticks"}, 16'(ticks - start), 16'(n));
  endtask
`endif

  initial begin
    #12;
    check("rst keys_a", 16'(keys_a), 16'h0);
    check("rst keys_b", 16'(keys_b), 16'h0);
    check("rst latch", 16'(key_latch), 16'h0);
    check("rst ef", 16'({ef3, ef4}), 16'h0);
    #10 reset_n = 1'b1;
    step();

    send(1'b1, 1'b0, 8'h16);
    check("a1 press", 16'(keys_a), 16'h002);
    out2(8'h01);
    check("latch 1", 16'(key_latch), 16'h1);
    check("ef3 latency", 16'(ef3), 16'h0);
    step();
    check("ef3 a1", 16'(ef3), 16'h1);
    check("ef4 a1", 16'(ef4), 16'h0);

    send(1'b1, 1'b0, 8'h45);
    check("a0 press", 16'(keys_a), 16'h003);
    out2(8'h0C);
    step();
    check("latch C", 16'(key_latch), 16'hC);
    check("ef out of range", 16'({ef3, ef4}), 16'h0);
    io_out = 1'b1; io_n = 3'd3; cpu_dout = 8'h05;
    step();
    io_out = 1'b0; io_n = 3'd2;
    step();
    io_n = 3'd0;
    check("latch hold", 16'(key_latch), 16'hC);
    out2(8'h00);
    step();
    check("ef3 a0", 16'(ef3), 16'h1);

    send(1'b1, 1'b0, 8'h4D);
    check("b0 press", 16'(keys_b), 16'h001);
    step();
    check("ef4 b0", 16'(ef4), 16'h1);
    send(1'b0, 1'b1, 8'h4D);
    check("ext ignored", 16'(keys_b), 16'h001);
    step();
    check("ef4 after ext", 16'(ef4), 16'h1);
    send(1'b1, 1'b0, 8'h1C);
    check("unmapped a", 16'(keys_a), 16'h003);
    check("unmapped b", 16'(keys_b), 16'h001);

    strobe   = ~strobe;
    ps2_key  = {strobe, 1'b1, 1'b0, 8'h46};
    io_out   = 1'b1; io_n = 3'd2; cpu_dout = 8'h09;
    step();
    io_out   = 1'b0; io_n = 3'd0;
    check("same edge keys", 16'(keys_a), 16'h203);
    check("same edge latch", 16'(key_latch), 16'h9);
    step();
    check("same edge ef3", 16'(ef3), 16'h1);
    check("same edge ef4", 16'(ef4), 16'h0);
    send(1'b1, 1'b0, 8'h44);
    check("b9 press", 16'(keys_b), 16'h201);
    step();
    check("ef4 b9", 16'(ef4), 16'h1);

    repeat (16) step();
    send(1'b0, 1'b0, 8'h16);
    check("a1 release", 16'(keys_a), 16'h201);

`ifdef STUDIO2_KEYPAD_STRETCH_EN
    send(1'b1, 1'b0, 8'h1E);
    t0 = ticks;
    check("s038 press", 16'(keys_a), 16'h205);
    send(1'b0, 1'b0, 8'h1E);
    wait_ticks("s038", t0, 3);
    check("s038 pend", 16'(keys_a[2]), 16'd1);
    step();
    check("s038 drop", 16'(keys_a), 16'h201);

    send(1'b1, 1'b0, 8'h1E);
    t0 = ticks;
    send(1'b0, 1'b0, 8'h1E);
    wait_ticks("s039a", t0, 1);
    check("s039 pend", 16'(keys_a[2]), 16'd1);
    send(1'b1, 1'b0, 8'h1E);
    t0 = ticks;
    check("s039 repress", 16'(keys_a[2]), 16'd1);
    send(1'b0, 1'b0, 8'h1E);
    wait_ticks("s039b", t0, 3);
    check("s039 pend2", 16'(keys_a[2]), 16'd1);
    step();
    check("s039 drop", 16'(keys_a), 16'h201);
`else
    send(1'b1, 1'b0, 8'h1E);
    check("a2 press", 16'(keys_a), 16'h205);
    send(1'b0, 1'b0, 8'h1E);
    check("a2 release now", 16'(keys_a), 16'h201);
`endif

    strobe  = ~strobe;
    ps2_key = {strobe, 1'b1, 1'b0, 8'h25};
    reset_n = 1'b0;
    #2;
    check("mid rst keys_a", 16'(keys_a), 16'h0);
    check("mid rst keys_b", 16'(keys_b), 16'h0);
    check("mid rst latch", 16'(key_latch), 16'h0);
    check("mid rst ef", 16'({ef3, ef4}), 16'h0);
    step();
    step();
    #4 reset_n = 1'b1;
    step();
    check("post rst no evt a", 16'(keys_a), 16'h0);
    check("post rst no evt b", 16'(keys_b), 16'h0);
    repeat (16) step();
    check("post rst idle", 16'(keys_a), 16'h0);
    check("post rst ef3", 16'(ef3), 16'h0);
    send(1'b1, 1'b0, 8'h3E);
    check("post rst press", 16'(keys_a), 16'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
